// File: rtl/fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// fp_mul_pipe
//
// Three-stage pipelined IEEE-754 floating-point multiplier with valid/ready
// handshakes on both sides. One product per cycle when the output is being
// drained. Results come back in order, three cycles after acceptance.
//
// Stage 1 : unpack, sign, biased exponent sum, operand classification
// Stage 2 : mantissa product (hidden bits included)
// Stage 3 : normalise, round, special-value / overflow / underflow select
//
// Subnormal operands are flushed to zero. Special operands produce Inf,
// signed zero or the canonical quiet NaN.
//
// Configuration macro:
//   FP_MUL_RNE_EN  defined   -> round-to-nearest-even
//                  undefined -> truncation (round toward zero)
//
// Parameters:
//   N  total word width
//   M  stored fraction width
//   E  exponent field width
//   B  exponent bias, 2^(E-1)-1
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair a/b valid
//   in_ready   block can accept an operand pair this cycle
//   a, b       operands {sign, exp[E], frac[M]}
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out        product
//   ovrf       overflow flag, qualified by out_valid
//   undrf      underflow flag, qualified by out_valid
//   invalid    invalid-operation flag, qualified by out_valid
// ---------------------------------------------------------------------------
module fp_mul_pipe #(
    parameter int N = 32,
    parameter int M = 23,
    parameter int E = 8,
    parameter int B = 127
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         ovrf,
    output logic         undrf,
    output logic         invalid
);

`ifdef FP_MUL_RNE_EN
    localparam int PW    = 2 * M + 2;
    localparam int SHIFT = 0;
`else
    localparam int PW    = M + 2;
    localparam int SHIFT = M;
`endif

    localparam logic signed [E+1:0] BIAS    = (E+2)'(B);
    localparam logic signed [E+1:0] ONE     = (E+2)'(1);
    localparam logic signed [E+1:0] ZERO_ES = '0;
    localparam logic signed [E+1:0] ES_MAX  = (E+2)'((1 << E) - 1);
    localparam logic [N-1:0]        QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic adv;

    logic [E-1:0] ea;
    logic [E-1:0] eb;
    logic [M-1:0] fa;
    logic [M-1:0] fb;
    logic         a_zero;
    logic         b_zero;
    logic         a_inf;
    logic         b_inf;
    logic         a_nan;
    logic         b_nan;
    logic signed [E+1:0] es_c;

    logic                s1_valid;
    logic                s1_sign;
    logic signed [E+1:0] s1_es;
    logic                s1_inv;
    logic                s1_inf;
    logic                s1_zero;
    logic [M:0]          s1_ma;
    logic [M:0]          s1_mb;

    logic                s2_valid;
    logic                s2_sign;
    logic signed [E+1:0] s2_es;
    logic                s2_inv;
    logic                s2_inf;
    logic                s2_zero;
    logic [PW-1:0]       s2_prod;

    logic                norm_hi;
    logic [M-1:0]        frac_n;
    logic signed [E+1:0] es_n;
    logic [M-1:0]        frac_r;
    logic signed [E+1:0] es_r;

    logic [N-1:0]        res;
    logic                r_ovrf;
    logic                r_undrf;
    logic                r_inv;

`ifdef FP_MUL_RNE_EN
    logic                guard;
    logic                sticky;
    logic                inc;
    logic [M:0]          frac_sum;
`endif

    // The whole pipeline moves as one: it advances whenever the output
    // register is empty or is being consumed this cycle, and stalls
    // otherwise. The input side is ready exactly when the pipe advances.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1 combinational: split the operands into fields, classify each
    // one and form the biased exponent sum. The sum is kept signed and two
    // bits wider than the field so that both overflow and underflow remain
    // visible after normalisation and rounding have added to it.
    always_comb begin
        ea     = a[N-2 -: E];
        eb     = b[N-2 -: E];
        fa     = a[M-1:0];
        fb     = b[M-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        es_c   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    end

    // Stage 1 valid bit. Only valids are reset; the datapath registers are
    // don't-care while their valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 datapath. The class of the pair is reduced to three bits here:
    // invalid (any NaN, or Inf times zero), any Inf, any zero. Stage 3 only
    // ever needs them in that priority order. Subnormals count as zero, so
    // their mantissa is never looked at downstream.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign <= a[N-1] ^ b[N-1];
            s1_es   <= es_c;
            s1_inv  <= a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
            s1_inf  <= a_inf || b_inf;
            s1_zero <= a_zero || b_zero;
            s1_ma   <= {1'b1, fa};
            s1_mb   <= {1'b1, fb};
        end
    end

    // Stage 2 valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
        end
    end

    // Stage 2 datapath: the mantissa product. With rounding enabled the full
    // 2M+2 bit product is kept because guard and sticky need the low bits.
    // With truncation only the bits that can reach the result fraction are
    // stored, so the low half of the product is dropped right here.
    always_ff @(posedge clk) begin
        if (adv) begin
            s2_sign <= s1_sign;
            s2_es   <= s1_es;
            s2_inv  <= s1_inv;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
            s2_prod <= PW'(({{(M+1){1'b0}}, s1_ma} * {{(M+1){1'b0}}, s1_mb}) >> SHIFT);
        end
    end

    // Stage 3 normalise. The product of two mantissas in [1,2) lies in
    // [1,4); when its top bit is set the binary point moves one place left,
    // which costs one exponent increment.
    always_comb begin
        norm_hi = s2_prod[PW-1];
        if (norm_hi) begin
            frac_n = s2_prod[PW-2 -: M];
            es_n   = s2_es + ONE;
        end else begin
            frac_n = s2_prod[PW-3 -: M];
            es_n   = s2_es;
        end
    end

`ifdef FP_MUL_RNE_EN
    // Stage 3 round-to-nearest-even. Round up when above the halfway point
    // or exactly on it with an odd fraction. A carry out of the fraction
    // means the mantissa reached 2.0: the fraction wraps to zero and the
    // exponent takes one more increment.
    always_comb begin
        if (norm_hi) begin
            guard  = s2_prod[M];
            sticky = |s2_prod[M-1:0];
        end else begin
            guard  = s2_prod[M-1];
            sticky = |s2_prod[M-2:0];
        end
        inc      = guard && (sticky || frac_n[0]);
        frac_sum = {1'b0, frac_n} + {{M{1'b0}}, inc};
        frac_r   = frac_sum[M-1:0];
        es_r     = frac_sum[M] ? (es_n + ONE) : es_n;
    end
`else
    // Stage 3 truncation: the bits below the fraction are simply discarded,
    // so there is no rounding carry and the exponent is unchanged.
    always_comb begin
        frac_r = frac_n;
        es_r   = es_n;
    end
`endif

    // Stage 3 result select, highest priority first: invalid operation,
    // infinite operand, zero operand, exponent overflow, exponent underflow,
    // normal result. Only the first, fourth and fifth cases raise a flag,
    // so at most one flag is ever set for a result.
    always_comb begin
        res     = {s2_sign, es_r[E-1:0], frac_r};
        r_ovrf  = 1'b0;
        r_undrf = 1'b0;
        r_inv   = 1'b0;
        if (s2_inv) begin
            res   = QNAN;
            r_inv = 1'b1;
        end else if (s2_inf) begin
            res = {s2_sign, {E{1'b1}}, {M{1'b0}}};
        end else if (s2_zero) begin
            res = {s2_sign, {(N-1){1'b0}}};
        end else if (es_r >= ES_MAX) begin
            res    = {s2_sign, {E{1'b1}}, {M{1'b0}}};
            r_ovrf = 1'b1;
        end else if (es_r <= ZERO_ES) begin
            res     = {s2_sign, {(N-1){1'b0}}};
            r_undrf = 1'b1;
        end
    end

    // Output register. Holds the result and its flags while the downstream
    // stalls; reset clears everything so no stale result is ever presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            ovrf      <= 1'b0;
            undrf     <= 1'b0;
            invalid   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out       <= res;
            ovrf      <= r_ovrf;
            undrf     <= r_undrf;
            invalid   <= r_inv;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_pipe
//
// Self-checking bench for fp_mul_pipe with default single-precision
// parameters. A behavioural reference model computes every expected result
// from plain integer arithmetic; a scoreboard queue pairs accepted operands
// with presented results. A table of hand-computed products pins the model.
// ---------------------------------------------------------------------------
module tb_fp_mul_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        ovrf;
    logic        undrf;
    logic        invalid;

    int          checks = 0;
    int          miscompares = 0;
    int          acc_total = 0;
    int          n;
    int          acc0;
    logic [34:0] exp_q[$];

    vec_t vecs [15] = '{
        {32'h40400000, 32'h40000000, 32'h40C00000, 3'b000},
        {32'h3FC00001, 32'h40000001, 32'h40400002, 3'b000},
        {32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100},
        {32'h00800000, 32'h00800000, 32'h00000000, 3'b010},
        {32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001},
        {32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
        {32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100},
        {32'h7E800000, 32'h40000000, 32'h7F000000, 3'b000},
        {32'h00800000, 32'h3F000000, 32'h00000000, 3'b010},
        {32'h00800000, 32'h3F800000, 32'h00800000, 3'b000},
        {32'h80000000, 32'h40000000, 32'h80000000, 3'b000},
        {32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b001},
        {32'h00000001, 32'h3F800000, 32'h00000000, 3'b000},
        {32'hC0000000, 32'h3F000000, 32'hBF800000, 3'b000},
        {32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b001}
    };

    logic [31:0] extra_a [4] = '{32'h3FB504F3, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'hC1234567};
    logic [31:0] extra_b [4] = '{32'h3FB504F3, 32'h3FFFFFFF, 32'h3F800001, 32'h42ABCDEF};

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovrf      (ovrf),
        .undrf     (undrf),
        .invalid   (invalid)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: {product, ovrf, undrf, invalid}. The mantissa
    // product is formed exactly in 64 bits, scaled so the value lies in
    // [1,2), and rounded by comparing the discarded remainder with half an
    // ulp.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        int     ex, ey, es, shift;
        longint fx, fy, p, mant, rem, half;
        bit     s, zx, zy, ix, iy, nx, ny;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = longint'(x[22:0]);
        fy = longint'(y[22:0]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (fx == 0);
        iy = (ey == 255) && (fy == 0);
        nx = (ex == 255) && (fx != 0);
        ny = (ey == 255) && (fy != 0);
        if (nx || ny || (ix && zy) || (zx && iy)) return {32'h7FC00000, 3'b001};
        if (ix || iy) return {s, 8'hFF, 23'h0, 3'b000};
        if (zx || zy) return {s, 31'h0, 3'b000};
        es = ex + ey - 127;
        p  = (fx + (longint'(1) << 23)) * (fy + (longint'(1) << 23));
        if (p >= (longint'(1) << 47)) begin
            shift = 24;
            es    = es + 1;
        end else begin
            shift = 23;
        end
        mant = p >> shift;
        rem  = p - (mant << shift);
        half = longint'(1) << (shift - 1);
`ifdef FP_MUL_RNE_EN
        if ((rem > half) || ((rem == half) && (mant[0] == 1'b1))) mant = mant + 1;
`else
        if (rem > half) mant = mant + 0;
`endif
        if (mant >= (longint'(1) << 24)) begin
            mant = mant >> 1;
            es   = es + 1;
        end
        if (es >= 255) return {s, 8'hFF, 23'h0, 3'b100};
        if (es <= 0) return {s, 31'h0, 3'b010};
        return {s, es[7:0], mant[22:0], 3'b000};
    endfunction

    // One comparison: counts it, and reports it when it differs.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Offers one operand pair and waits (bounded) until it is accepted.
    // Returns just after the accepting clock edge with in_valid dropped.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
        bit hs;
        bit done;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            if (hs) done = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: operands %h x %h not accepted", av, bv);
        end
    endtask

    // Waits (bounded) until every accepted pair has come back out.
    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(negedge clk);
            #1;
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Counts from the accept edge to the first cycle out_valid is seen.
    task automatic measureLatency(input string name);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        checkOutput(name, 64'(n), 64'd3);
    endtask

    // Scoreboard. Every cycle the output is valid it must equal the oldest
    // outstanding expectation, including every cycle it is held by a stall;
    // the expectation is retired only when the result is consumed. A valid
    // output with nothing outstanding is a duplicate or a ghost. Reset
    // discards everything in flight.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    miscompares++;
                    $display("[TB] FAIL spurious_result: got %h with nothing outstanding at %0t", out, $time);
                end else begin
                    checkOutput("result", 64'({out, ovrf, undrf, invalid}), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                acc_total++;
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
`ifdef FP_MUL_RNE_EN
        vecs[1].r = 32'h40400003;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_state", 64'({out_valid, out, ovrf, undrf, invalid, in_ready}),
                    64'({1'b0, 32'h0, 3'b000, 1'b1}));

        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("model_pin_%0d", i), 64'(model(vecs[i].a, vecs[i].b)),
                        64'({vecs[i].r, vecs[i].f}));
        end

        $display("[TB] basic product and latency");
        @(posedge clk);
        #1;
        applyStimulus(32'h40400000, 32'h40000000);
        measureLatency("latency_basic");
        checkOutput("basic_value", 64'({out, ovrf, undrf, invalid}), 64'({32'h40C00000, 3'b000}));
        drain("drain_basic");

        $display("[TB] directed table back to back");
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i].a, vecs[i].b);
        for (int i = 0; i < 4; i++) applyStimulus(extra_a[i], extra_b[i]);
        drain("drain_table");

        $display("[TB] backpressure");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        acc0      = acc_total;
        fork
            begin
                applyStimulus(32'h3F800000, 32'h3F800000);
                applyStimulus(32'h40400000, 32'h40400000);
                applyStimulus(32'hC0000000, 32'h3F000000);
                applyStimulus(32'h3FC00001, 32'h40000001);
            end
            begin
                repeat (6) @(negedge clk);
                #1;
                checkOutput("bp_accepted", 64'(acc_total - acc0), 64'd3);
                checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
                checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_bp");
        checkOutput("bp_total", 64'(acc_total - acc0), 64'd4);

        $display("[TB] reset with items in flight");
        @(posedge clk);
        #1;
        applyStimulus(32'h40400000, 32'h40000000);
        applyStimulus(32'h3F800000, 32'hBF800000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("rst_flushed", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h40400000, 32'h40400000);
        measureLatency("latency_after_rst");
        checkOutput("after_rst_value", 64'({out, ovrf, undrf, invalid}), 64'({32'h41100000, 3'b000}));
        drain("drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
